div_param: RTL and testbench
============================

DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 Parameter: WIDTH, default 8; operand, quotient and remainder width in bits, legal values 2..32.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a division; sampled only while ready=1.
REQ-005 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: dividend  input  WIDTH  dividend operand; sampled with start.
REQ-007 Port: divisor  input  WIDTH  divisor operand; sampled with start.
REQ-008 Port: quotient  output  WIDTH  result quotient, registered.
REQ-009 Port: remainder  output  WIDTH  result remainder, registered.
REQ-010 Port: ready  output  1  block idle and able to accept start.
REQ-011 Port: done  output  1  one-cycle pulse marking valid results.
REQ-012 Port: div_by_zero  output  1  last operation had divisor = 0.
REQ-013 Port: overflow  output  1  last operation was signed MIN / -1.

Function
REQ-014 States SHALL be IDLE, RUN, FIX and DONE; ready SHALL be 1 only in IDLE with reset deasserted.
REQ-015 IDLE with start=1 SHALL latch the operands and signed_mode, clear div_by_zero and overflow, load the counter with WIDTH-1 and go to RUN.
REQ-016 At load, if divisor=0 the block SHALL go straight to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-017 At load, if signed, dividend = 2^(WIDTH-1) pattern and divisor = all ones, the block SHALL go straight to DONE with quotient = dividend, remainder=0, overflow=1.
REQ-018 In signed mode the magnitudes of the operands SHALL be divided, and the result signs recorded at load.
REQ-019 RUN SHALL perform one restoring shift/subtract step per cycle, producing one quotient bit MSB first; after WIDTH steps it SHALL go to FIX.
REQ-020 Division SHALL truncate toward zero; the remainder sign SHALL follow the dividend; |remainder| SHALL be less than |divisor|.
REQ-021 FIX SHALL negate the quotient and/or remainder as required, write both outputs and go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-023 Normal latency: done SHALL be high during the cycle after WIDTH+2 edges, counted from the edge that samples start inclusive.
REQ-024 Short-circuit latency (REQ-016/017): done SHALL be high during the cycle after the sampling edge.
REQ-025 start while ready=0, including the DONE cycle, SHALL be ignored with no queuing.
REQ-026 quotient, remainder, div_by_zero and overflow SHALL hold stable from DONE until the next accepted start.
REQ-027 Internal subtraction SHALL use WIDTH+1 bits so that no partial remainder overflows for any WIDTH.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counter=0, quotient=0, remainder=0, done=0, div_by_zero=0, overflow=0; ready=0 while held.
REQ-029 Reset asserted mid-operation SHALL abort it without a done pulse; ready SHALL be 1 on the first cycle after release.

Configuration
REQ-030 Macro DIV_SIGNED_EN defined: signed_mode SHALL be honoured per REQ-017/018/020/021.
REQ-031 Macro DIV_SIGNED_EN undefined: signed_mode SHALL be ignored, all operations unsigned, overflow tied 0, and FIX SHALL only transfer results (latency unchanged); the port list SHALL be identical.

Verification (WIDTH=8, DIV_SIGNED_EN defined unless noted)
REQ-032 Unsigned 200/7 -> quotient=28, remainder=4, done on cycle 10 after start edge, flags 0.
REQ-033 Signed -100/7 (0x9C/0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2); signed 100/-7 -> 0xF2, 0x02.
REQ-034 55/0 -> quotient=0xFF, remainder=55, div_by_zero=1, done one cycle after start; signed 0x80/0xFF -> quotient=0x80, remainder=0, overflow=1.
REQ-035 Start 200/7, pulse start again in cycle 3, assert reset in cycle 5 -> second start ignored, no done, all outputs 0, ready=1 after release.
REQ-036 DIV_SIGNED_EN undefined, signed_mode=1, 0x9C/0x07 -> quotient=22, remainder=2, overflow=0.

Source files
------------

// File: rtl/div_param.sv
// Iterative restoring divider, one quotient bit per cycle, IDLE/RUN/FIX/DONE.
// Define DIV_SIGNED_EN to honour signed_mode; otherwise every operation is unsigned.
module div_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

`ifdef DIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rem;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_quo_o;
    logic [WIDTH-1:0] r_rem_o;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_sgn;
    logic             w_dd_neg;
    logic             w_dv_neg;
    logic [WIDTH-1:0] w_dd_abs;
    logic [WIDTH-1:0] w_dv_abs;
    logic             w_zero;
    logic             w_ovf_case;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;

    assign w_sgn      = signed_mode & SIGNED_EN;
    assign w_dd_neg   = w_sgn & dividend[WIDTH-1];
    assign w_dv_neg   = w_sgn & divisor[WIDTH-1];
    assign w_dd_abs   = w_dd_neg ? -dividend : dividend;
    assign w_dv_abs   = w_dv_neg ? -divisor : divisor;
    assign w_zero     = (divisor == '0);
    assign w_ovf_case = w_sgn && (dividend == MIN_VAL) && (divisor == '1);

    // Partial remainder is always below the divisor, so the shifted value
    // fits WIDTH+1 bits; the top bit of the difference is the borrow.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_sub   = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_sub[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_zero || w_ovf_case) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_dvs   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_quo_o <= '0;
            r_rem_o <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvs  <= w_dv_abs;
                        r_acc  <= w_dd_abs;
                        r_rem  <= '0;
                        r_cnt  <= CW'(WIDTH - 1);
                        r_qneg <= w_dd_neg ^ w_dv_neg;
                        r_rneg <= w_dd_neg;
                        r_dbz  <= w_zero;
                        r_ovf  <= w_ovf_case;
                        if (w_zero) begin
                            r_quo_o <= '1;
                            r_rem_o <= dividend;
                        end else if (w_ovf_case) begin
                            r_quo_o <= dividend;
                            r_rem_o <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= {r_acc[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_quo_o <= r_qneg ? -r_acc : r_acc;
                    r_rem_o <= r_rneg ? -r_rem : r_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quo_o;
    assign remainder   = r_rem_o;
    assign ready       = (r_state == S_IDLE) && reset;
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;
    assign overflow    = SIGNED_EN ? r_ovf : 1'b0;

endmodule

// File: tb/tb_div_param.sv
// Directed bench for div_param at WIDTH=8.
// Expectations follow DIV_SIGNED_EN as seen by this compilation.
module tb_div_param;

`ifdef DIV_SIGNED_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       ready;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        logic       v;
        int         lat;
    } vec_t;

    div_param #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one division from IDLE; lat = edges from the sampling edge
    // until done is seen, 0 if done never arrives within the budget.
    task automatic run_div(input logic sm, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [7:0] q, output logic [7:0] r,
                           output logic z, output logic v);
        @(negedge clk);
        start = 1'b1;
        signed_mode = sm;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        v = overflow;
    endtask

    task automatic run_vectors(input string name, input vec_t vs[$]);
        int lat;
        logic [7:0] q, r;
        logic z, v;
        foreach (vs[k]) begin
            run_div(vs[k].sm, vs[k].a, vs[k].b, lat, q, r, z, v);
            n_cmp++;
            if (lat != vs[k].lat) begin
                n_err++;
                $display("FAIL %s[%0d] latency: got %0d expected %0d", name, k, lat, vs[k].lat);
            end
            n_cmp++;
            if ({q, r, z, v} !== {vs[k].q, vs[k].r, vs[k].z, vs[k].v}) begin
                n_err++;
                $display("FAIL %s[%0d] result: got q=%h r=%h z=%b v=%b expected q=%h r=%h z=%b v=%b",
                         name, k, q, r, z, v, vs[k].q, vs[k].r, vs[k].z, vs[k].v);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready, done, div_by_zero, overflow, quotient, remainder} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_hold: got rdy=%b done=%b z=%b v=%b q=%h r=%h expected all 0",
                     ready, done, div_by_zero, overflow, quotient, remainder);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ready, done} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b done=%b expected rdy=1 done=0", ready, done);
        end
    endtask

    task automatic test_unsigned();
        vec_t vs[$];
        vs.push_back('{1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 10});
        vs.push_back('{1'b0, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0, 10});
        vs.push_back('{1'b0, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0, 10});
        vs.push_back('{1'b0, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 10});
        run_vectors("unsigned", vs);
        @(negedge clk);
        n_cmp++;
        if ({done, ready} !== 2'b01) begin
            n_err++;
            $display("FAIL done_pulse: got done=%b rdy=%b expected done=0 rdy=1", done, ready);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({quotient, remainder} !== {8'd255, 8'd0}) begin
            n_err++;
            $display("FAIL hold: got q=%h r=%h expected q=ff r=00", quotient, remainder);
        end
    endtask

    task automatic test_signed();
        vec_t vs[$];
        vs.push_back('{1'b1, 8'h9C, 8'h07, SE ? 8'hF2 : 8'd22, SE ? 8'hFE : 8'd2, 1'b0, 1'b0, 10});
        vs.push_back('{1'b1, 8'h64, 8'hF9, SE ? 8'hF2 : 8'h00, SE ? 8'h02 : 8'h64, 1'b0, 1'b0, 10});
        vs.push_back('{1'b1, 8'hF9, 8'h02, SE ? 8'hFD : 8'h7C, SE ? 8'hFF : 8'h01, 1'b0, 1'b0, 10});
        vs.push_back('{1'b1, 8'h80, 8'h02, SE ? 8'hC0 : 8'h40, 8'h00, 1'b0, 1'b0, 10});
        vs.push_back('{1'b1, 8'h14, 8'h05, 8'h04, 8'h00, 1'b0, 1'b0, 10});
        run_vectors("signed", vs);
    endtask

    task automatic test_div_zero();
        vec_t vs[$];
        vs.push_back('{1'b0, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1'b0, 1});
        vs.push_back('{1'b1, 8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, 1'b0, 1});
        vs.push_back('{1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 10});
        run_vectors("div_zero", vs);
    endtask

    task automatic test_overflow();
        vec_t vs[$];
        vs.push_back('{1'b1, 8'h80, 8'hFF, SE ? 8'h80 : 8'h00, SE ? 8'h00 : 8'h80,
                       1'b0, SE, SE ? 1 : 10});
        vs.push_back('{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 10});
        run_vectors("overflow", vs);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] q, r;
        logic z, v;
        run_div(1'b0, 8'd200, 8'd7, lat, q, r, z, v);
        start = 1'b1;
        dividend = 8'd10;
        divisor = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, ready, quotient} !== {1'b0, 1'b1, 8'd28}) begin
            n_err++;
            $display("FAIL start_in_done: got done=%b rdy=%b q=%h expected done=0 rdy=1 q=1c",
                     done, ready, quotient);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL no_queue: got rdy=%b expected 1", ready);
        end
        run_div(1'b0, 8'd10, 8'd3, lat, q, r, z, v);
        n_cmp++;
        if ({lat[7:0], q, r} !== {8'd10, 8'd3, 8'd1}) begin
            n_err++;
            $display("FAIL back_to_back: got lat=%0d q=%h r=%h expected lat=10 q=03 r=01", lat, q, r);
        end
    endtask

    task automatic test_abort();
        int lat;
        logic [7:0] q, r;
        logic z, v;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        signed_mode = 1'b0;
        dividend = 8'd200;
        divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= done;
        end
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd3;
        @(negedge clk);
        seen |= done;
        start = 1'b0;
        @(negedge clk);
        seen |= done;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, done, div_by_zero, overflow, quotient, remainder} !== 20'h0) begin
            n_err++;
            $display("FAIL abort_reset: got rdy=%b done=%b z=%b v=%b q=%h r=%h expected all 0",
                     ready, done, div_by_zero, overflow, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ready, done} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_release: got rdy=%b done=%b expected rdy=1 done=0", ready, done);
        end
        repeat (12) begin
            @(negedge clk);
            seen |= done;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got done seen=%b expected 0", seen);
        end
        run_div(1'b0, 8'd200, 8'd7, lat, q, r, z, v);
        n_cmp++;
        if ({lat[7:0], q, r} !== {8'd10, 8'd28, 8'd4}) begin
            n_err++;
            $display("FAIL after_abort: got lat=%0d q=%h r=%h expected lat=10 q=1c r=04", lat, q, r);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
